switch_alloc_ctrl: RTL and testbench
====================================

// Module: switch_alloc_ctrl
// PURPOSE
//  Sequential allocator driving the select inputs of the router crossbar switch (switch_new_des).
//  Arbitrates between three flit sources: NI injection -> down, VC1 transit -> down, VC0 -> local NI.
//  Holds a grant for a whole packet until its tail flit (8'd255) has been transferred.
//  Generates buffer pop strobes and a packet-length watchdog.
//  Sits directly upstream of the switch; the switch's ena_* tail-detect outputs feed back into it.
// PARAMETERS
//  MAX_PKT_LEN  16  max flits per packet incl. tail; watchdog limit (>=2)
//  CNT_W        5   flit counter width; must satisfy 2**CNT_W > MAX_PKT_LEN
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  ni_valid     in   1  NI injection buffer non-empty (head flit on switch NI_in)
//  vc1_valid    in   1  VC1 buffer non-empty (head flit on switch vc1_in)
//  vc0_valid    in   1  VC0 buffer non-empty (head flit on switch vc0_in)
//  ena_ni       in   1  from switch: NI_in head flit == 8'd255 (tail)
//  ena_vc1      in   1  from switch: vc1_in head flit == 8'd255
//  ena_vc0      in   1  from switch: vc0_in head flit == 8'd255
//  down_ready   in   1  downstream router can accept a flit on out_down this cycle
//  ni_ready     in   1  local NI can accept a flit on out_NI this cycle
//  sel_NI_out   out  1  to switch, registered
//  sel_vc       out  1  to switch, registered
//  sel_up       out  1  to switch, registered
//  pop_ni       out  1  pop NI buffer head (flit transferred this cycle)
//  pop_vc1      out  1  pop VC1 buffer head
//  pop_vc0      out  1  pop VC0 buffer head
//  busy         out  1  a grant is active (state != IDLE)
//  err_timeout  out  1  one-cycle pulse: packet released by watchdog
// BEHAVIOUR
//  - FSM states: IDLE, G_NI, G_VC1, G_VC0. Select encoding {sel_NI_out,sel_vc,sel_up}:
//    IDLE=000, G_NI=010, G_VC1=011, G_VC0=100. Sel outputs are decoded from registered state only.
//  - Reset (async): state=IDLE, sel=000, rr_ptr=NI, flit_cnt=0, err_timeout=0; pops/busy=0.
//  - IDLE: if any *_valid is high, grant the first requester at or after rr_ptr in the cyclic order
//    NI -> VC1 -> VC0 -> NI; enter G_x at the next edge. No request: stay IDLE.
//    Request-to-grant latency = 1 cycle. One IDLE bubble cycle between consecutive packets.
//  - G_x: pop_x = x_valid & rdy, combinational, where rdy = down_ready (G_NI, G_VC1) or ni_ready (G_VC0).
//    Non-granted pops are always 0. Each pop increments flit_cnt.
//  - Tail: a pop with ena_x=1 -> IDLE at the next edge; rr_ptr = source after x; flit_cnt=0.
//  - Watchdog: a pop without tail that brings flit_cnt to MAX_PKT_LEN -> IDLE, rr_ptr advanced,
//    flit_cnt=0, err_timeout=1 for exactly the next cycle.
//  - Backpressure (rdy=0) or empty buffer (x_valid=0) in G_x: no pop; state, sel and flit_cnt are held.
//    Grant is never revoked mid-packet except by the watchdog or reset.
//  - ena_x asserted without x_valid is ignored.
//  - Reset mid-packet: immediate return to IDLE, sel=000. Partial packet stays in its buffer; the
//    upstream is responsible for the resulting packet fragment.
//  - rr_ptr updates only on packet release; it is unchanged while IDLE with no requests.
// TESTING
//  1 Assert rst mid-cycle -> sel=000, all pops=0, busy=0, err_timeout=0 immediately.
//  2 NI packet 8'h81,8'h22,8'hFF; down_ready=1 -> sel=010 one cycle after ni_valid; pop_ni 3 cycles; then IDLE/000.
//  3 ni/vc1/vc0_valid all high, each with 2-flit packets -> grant order G_NI, G_VC1, G_VC0 (010,011,100),
//    one IDLE cycle between each.
//  4 VC1 granted; down_ready=0 for 3 cycles after first flit -> pop_vc1=0, sel held 011; then resumes; tail -> IDLE.
//  5 MAX_PKT_LEN=4; VC0 streams non-tail flits -> 4 pops, err_timeout pulses once, IDLE, rr_ptr=NI.
//  6 vc0_valid=1 with ni_ready=0 -> G_VC0 held, no pops; vc1 request waits until VC0 tail is popped.

Source files
------------

// File: rtl/switch_alloc_ctrl.sv
// Crossbar select allocator: round-robin packet grants between NI injection, VC1 transit and VC0,
// held until the tail flit is popped or the packet-length watchdog releases it.
module switch_alloc_ctrl #(
   parameter int MAX_PKT_LEN = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic ni_valid,
   input  logic vc1_valid,
   input  logic vc0_valid,
   input  logic ena_ni,
   input  logic ena_vc1,
   input  logic ena_vc0,
   input  logic down_ready,
   input  logic ni_ready,
   output logic sel_NI_out,
   output logic sel_vc,
   output logic sel_up,
   output logic pop_ni,
   output logic pop_vc1,
   output logic pop_vc0,
   output logic busy,
   output logic err_timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, G_NI = 2'd1, G_VC1 = 2'd2, G_VC0 = 2'd3} state_t;

   localparam logic [1:0] SRC_NI  = 2'd0;
   localparam logic [1:0] SRC_VC1 = 2'd1;
   localparam logic [1:0] SRC_VC0 = 2'd2;

   state_t           state, state_nxt;
   logic [1:0]       rr_ptr, rr_nxt;
   logic [CNT_W-1:0] flit_cnt, cnt_nxt;
   logic             timeout_nxt;
   logic             grant_pop, grant_tail;
   logic [1:0]       cur_src;

   function automatic logic [1:0] next_src(input logic [1:0] s);
      case (s)
         SRC_NI:  next_src = SRC_VC1;
         SRC_VC1: next_src = SRC_VC0;
         default: next_src = SRC_NI;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= SRC_NI;
         flit_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_nxt;
         flit_cnt    <= cnt_nxt;
         err_timeout <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      rr_nxt      = rr_ptr;
      cnt_nxt     = flit_cnt;
      timeout_nxt = 1'b0;
      pop_ni      = 1'b0;
      pop_vc1     = 1'b0;
      pop_vc0     = 1'b0;
      grant_pop   = 1'b0;
      grant_tail  = 1'b0;
      cur_src     = SRC_NI;
      case (state)
         IDLE: begin
            // search order starts at rr_ptr and wraps NI -> VC1 -> VC0
            case (rr_ptr)
               SRC_VC1: begin
                  if (vc1_valid)      state_nxt = G_VC1;
                  else if (vc0_valid) state_nxt = G_VC0;
                  else if (ni_valid)  state_nxt = G_NI;
               end
               SRC_VC0: begin
                  if (vc0_valid)      state_nxt = G_VC0;
                  else if (ni_valid)  state_nxt = G_NI;
                  else if (vc1_valid) state_nxt = G_VC1;
               end
               default: begin
                  if (ni_valid)       state_nxt = G_NI;
                  else if (vc1_valid) state_nxt = G_VC1;
                  else if (vc0_valid) state_nxt = G_VC0;
               end
            endcase
         end
         G_NI: begin
            pop_ni     = ni_valid & down_ready;
            grant_pop  = pop_ni;
            grant_tail = ena_ni;
            cur_src    = SRC_NI;
         end
         G_VC1: begin
            pop_vc1    = vc1_valid & down_ready;
            grant_pop  = pop_vc1;
            grant_tail = ena_vc1;
            cur_src    = SRC_VC1;
         end
         G_VC0: begin
            pop_vc0    = vc0_valid & ni_ready;
            grant_pop  = pop_vc0;
            grant_tail = ena_vc0;
            cur_src    = SRC_VC0;
         end
         default: state_nxt = IDLE;
      endcase

      // a tail is only honoured when it is actually popped
      if (grant_pop) begin
         if (grant_tail) begin
            state_nxt = IDLE;
            rr_nxt    = next_src(cur_src);
            cnt_nxt   = '0;
         end else if (flit_cnt == CNT_W'(MAX_PKT_LEN - 1)) begin
            state_nxt   = IDLE;
            rr_nxt      = next_src(cur_src);
            cnt_nxt     = '0;
            timeout_nxt = 1'b1;
         end else begin
            cnt_nxt = flit_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      case (state)
         G_NI:    {sel_NI_out, sel_vc, sel_up} = 3'b010;
         G_VC1:   {sel_NI_out, sel_vc, sel_up} = 3'b011;
         G_VC0:   {sel_NI_out, sel_vc, sel_up} = 3'b100;
         default: {sel_NI_out, sel_vc, sel_up} = 3'b000;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_switch_alloc_ctrl.sv
// Directed table-driven bench for switch_alloc_ctrl (watchdog limit shortened to 4 flits).
module tb_switch_alloc_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic ni_valid, vc1_valid, vc0_valid;
   logic ena_ni, ena_vc1, ena_vc0;
   logic down_ready, ni_ready;
   logic sel_NI_out, sel_vc, sel_up;
   logic pop_ni, pop_vc1, pop_vc0;
   logic busy, err_timeout;
   logic [7:0] obs;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   switch_alloc_ctrl #(.MAX_PKT_LEN(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .ni_valid(ni_valid), .vc1_valid(vc1_valid), .vc0_valid(vc0_valid),
      .ena_ni(ena_ni), .ena_vc1(ena_vc1), .ena_vc0(ena_vc0),
      .down_ready(down_ready), .ni_ready(ni_ready),
      .sel_NI_out(sel_NI_out), .sel_vc(sel_vc), .sel_up(sel_up),
      .pop_ni(pop_ni), .pop_vc1(pop_vc1), .pop_vc0(pop_vc0),
      .busy(busy), .err_timeout(err_timeout)
   );

   // observed word: {sel_NI_out,sel_vc,sel_up, pop_ni,pop_vc1,pop_vc0, busy, err_timeout}
   assign obs = {sel_NI_out, sel_vc, sel_up, pop_ni, pop_vc1, pop_vc0, busy, err_timeout};

   // stimulus word: {ni_valid,vc1_valid,vc0_valid, ena_ni,ena_vc1,ena_vc0, down_ready,ni_ready}
   typedef struct {
      logic       r;
      logic [7:0] in;
      logic [7:0] exp;
      int         grp;
   } vec_t;

   vec_t vecs[$];

   task automatic drive(input logic r, input logic [7:0] in);
      rst = r;
      {ni_valid, vc1_valid, vc0_valid, ena_ni, ena_vc1, ena_vc0, down_ready, ni_ready} = in;
   endtask

   task automatic check(input string name, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got sel/pop/busy/err=%b expected %b", name, obs, exp);
      end
   endtask

   task automatic add(input logic r, input logic [7:0] in, input logic [7:0] exp, input int grp);
      vec_t v;
      v.r = r; v.in = in; v.exp = exp; v.grp = grp;
      vecs.push_back(v);
   endtask

   initial begin
      drive(1'b1, 8'b000_000_00);
      #2;
      check("reset_state", 8'b000_000_00);

      // NI packet 81,22,FF
      add(0, 8'b100_000_10, 8'b000_000_00, 2);
      add(0, 8'b100_000_10, 8'b010_100_10, 2);
      add(0, 8'b100_000_10, 8'b010_100_10, 2);
      add(0, 8'b100_100_10, 8'b010_100_10, 2);
      add(0, 8'b000_000_11, 8'b000_000_00, 2);
      // all three request, 2-flit packets, round-robin from NI
      add(1, 8'b111_000_11, 8'b000_000_00, 3);
      add(0, 8'b111_000_11, 8'b000_000_00, 3);
      add(0, 8'b111_000_11, 8'b010_100_10, 3);
      add(0, 8'b111_100_11, 8'b010_100_10, 3);
      add(0, 8'b111_000_11, 8'b000_000_00, 3);
      add(0, 8'b111_000_11, 8'b011_010_10, 3);
      add(0, 8'b111_010_11, 8'b011_010_10, 3);
      add(0, 8'b111_000_11, 8'b000_000_00, 3);
      add(0, 8'b111_000_11, 8'b100_001_10, 3);
      add(0, 8'b111_001_11, 8'b100_001_10, 3);
      add(0, 8'b000_000_11, 8'b000_000_00, 3);
      // VC1 with 3 cycles of down backpressure, plus ena without valid
      add(0, 8'b010_000_11, 8'b000_000_00, 4);
      add(0, 8'b010_000_11, 8'b011_010_10, 4);
      add(0, 8'b010_000_01, 8'b011_000_10, 4);
      add(0, 8'b010_000_01, 8'b011_000_10, 4);
      add(0, 8'b010_000_01, 8'b011_000_10, 4);
      add(0, 8'b010_000_11, 8'b011_010_10, 4);
      add(0, 8'b000_010_11, 8'b011_000_10, 4);
      add(0, 8'b010_010_11, 8'b011_010_10, 4);
      add(0, 8'b000_000_11, 8'b000_000_00, 4);
      // VC0 blocked by ni_ready=0 while VC1 waits
      add(0, 8'b011_000_10, 8'b000_000_00, 6);
      add(0, 8'b011_000_10, 8'b100_000_10, 6);
      add(0, 8'b011_000_10, 8'b100_000_10, 6);
      add(0, 8'b011_000_11, 8'b100_001_10, 6);
      add(0, 8'b011_001_11, 8'b100_001_10, 6);
      add(0, 8'b010_000_11, 8'b000_000_00, 6);
      add(0, 8'b010_010_11, 8'b011_010_10, 6);
      add(0, 8'b000_000_11, 8'b000_000_00, 6);
      // watchdog: VC0 streams 4 non-tail flits, then rr_ptr must be NI
      add(0, 8'b001_000_11, 8'b000_000_00, 5);
      add(0, 8'b001_000_11, 8'b100_001_10, 5);
      add(0, 8'b001_000_11, 8'b100_001_10, 5);
      add(0, 8'b001_000_11, 8'b100_001_10, 5);
      add(0, 8'b001_000_11, 8'b100_001_10, 5);
      add(0, 8'b111_000_11, 8'b000_000_01, 5);
      add(0, 8'b111_100_11, 8'b010_100_10, 5);
      add(0, 8'b000_000_11, 8'b000_000_00, 5);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].r, vecs[i].in);
         #2;
         check($sformatf("grp%0d_vec%0d", vecs[i].grp, i), vecs[i].exp);
      end

      // asynchronous reset in the middle of a granted NI packet
      @(negedge clk);
      drive(1'b0, 8'b100_000_10);
      #2;
      check("midrst_idle", 8'b000_000_00);
      @(negedge clk);
      #2;
      check("midrst_granted", 8'b010_100_10);
      #1 rst = 1'b1;
      #1;
      check("midrst_async", 8'b000_000_00);
      @(negedge clk);
      drive(1'b0, 8'b100_000_10);
      #2;
      check("midrst_after", 8'b000_000_00);
      @(negedge clk);
      drive(1'b0, 8'b100_100_10);
      #2;
      check("midrst_regrant", 8'b010_100_10);
      @(negedge clk);
      drive(1'b0, 8'b000_000_11);
      #2;
      check("midrst_release", 8'b000_000_00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
